// File: rtl/pn_stack_eval.sv
// Polish-notation expression evaluator.
// Buffers one expression of tokens, then evaluates it one token per cycle
// on an internal operand stack. Prefix expressions are walked from the last
// token back to the first, with the operand order swapped on each pop.
module pn_stack_eval #(
  parameter int IN_W    = 3,
  parameter int DATA_W  = 32,
  parameter int MAX_TOK = 16,
  parameter int STACK_D = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  input  logic              operator,
  input  logic [IN_W-1:0]   in,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic [4:0]        err
);

  localparam int CW = $clog2(MAX_TOK + 1);
  localparam int TW = (MAX_TOK > 1) ? $clog2(MAX_TOK) : 1;
  localparam int PW = $clog2(STACK_D + 1);
  localparam int SW = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

  state_t state, state_nx;

  logic                     mode_q;
  logic                     tok_op  [MAX_TOK];
  logic [IN_W-1:0]          tok_val [MAX_TOK];
  logic [CW-1:0]            count;
  logic [CW-1:0]            step;
  logic [PW-1:0]            sp;
  logic signed [DATA_W-1:0] stack [STACK_D];

  logic err_tok, err_ovf, err_unf, err_ill;

  logic                     accept;
  logic                     last_step;
  logic                     tok_full;
  logic [CW-1:0]            pos;
  logic [TW-1:0]            rd_idx;
  logic                     cur_op;
  logic [IN_W-1:0]          cur_val;
  logic                     cur_illegal;
  logic signed [DATA_W-1:0] top_v, nxt_v, opa, opb, sum, alu_res, push_v;
  logic [4:0]               err_all;

  assign accept    = in_valid && in_ready;
  assign tok_full  = (count == CW'(MAX_TOK));
  assign last_step = (step == count - CW'(1));

  // Select the token being evaluated and compute the operator result
  always_comb begin
    pos         = mode_q ? step : (count - CW'(1) - step);
    rd_idx      = TW'(pos);
    cur_op      = tok_op[rd_idx];
    cur_val     = tok_val[rd_idx];
    cur_illegal = (cur_val > IN_W'(5));
    top_v       = stack[SW'(sp - PW'(1))];
    nxt_v       = stack[SW'(sp - PW'(2))];
    // postfix pops b first; prefix pops a first
    opa         = mode_q ? nxt_v : top_v;
    opb         = mode_q ? top_v : nxt_v;
    sum         = opa + opb;
    push_v      = {{(DATA_W-IN_W){1'b0}}, cur_val};
    case (cur_val)
      IN_W'(0): alu_res = sum;
      IN_W'(1): alu_res = opa - opb;
      IN_W'(2): alu_res = opa * opb;
      IN_W'(3): alu_res = sum[DATA_W-1] ? -sum : sum;
      IN_W'(4): alu_res = (opa > opb) ? opa : opb;
      IN_W'(5): alu_res = (opa < opb) ? opa : opb;
      default:  alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = in_last ? EVAL : LOAD;
      LOAD: if (accept && in_last) state_nx = EVAL;
      EVAL: if (last_step) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; result and flags only visible in DONE
  always_comb begin
    in_ready  = (state == IDLE) || (state == LOAD);
    out_valid = (state == DONE);
    err_all   = {err_ill, (sp != PW'(1)), err_unf, err_ovf, err_tok};
    err       = '0;
    out       = '0;
    if (state == DONE) begin
      err = err_all;
      if (err_all == 5'd0) out = stack[0];
    end
  end

  // Token count, evaluation step, stack pointer and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 1'b0;
      count   <= '0;
      step    <= '0;
      sp      <= '0;
      err_tok <= 1'b0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      err_ill <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mode_q  <= mode;
          count   <= CW'(1);
          step    <= '0;
          sp      <= '0;
          err_tok <= 1'b0;
          err_ovf <= 1'b0;
          err_unf <= 1'b0;
          err_ill <= 1'b0;
        end
        LOAD: if (accept) begin
          if (tok_full) err_tok <= 1'b1;
          else          count   <= count + CW'(1);
        end
        EVAL: begin
          step <= step + CW'(1);
          if (!cur_op) begin
            if (sp == PW'(STACK_D)) err_ovf <= 1'b1;
            else                    sp      <= sp + PW'(1);
          end else begin
            if (cur_illegal) err_ill <= 1'b1;
            if (sp < PW'(2)) err_unf <= 1'b1;
            else             sp      <= sp - PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Token buffer writes; tokens past the buffer depth are dropped
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      tok_op[0]  <= operator;
      tok_val[0] <= in;
    end else if (state == LOAD && accept && !tok_full) begin
      tok_op[TW'(count)]  <= operator;
      tok_val[TW'(count)] <= in;
    end
  end

  // Operand stack writes: push an operand, or replace the two top entries with the result
  always_ff @(posedge clk) begin
    if (state == EVAL) begin
      if (!cur_op) begin
        if (sp != PW'(STACK_D)) stack[SW'(sp)] <= push_v;
      end else if (sp >= PW'(2)) begin
        stack[SW'(sp - PW'(2))] <= alu_res;
      end
    end
  end

endmodule
